// File: rtl/bus_addr_decoder.sv
// Address decoder for a simple valid/ready bus. Generates one-hot write strobes,
// a held read-mux select and a sticky error for unmapped accesses.

module bus_addr_decoder_match #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] mask,
    input  logic [AW-1:0] addr,
    output logic          hit
);
    assign hit = ((addr & mask) == (base & mask));
endmodule

module bus_addr_decoder #(
    parameter int                 NS       = 3,
    parameter int                 AW       = 32,
    parameter logic [NS*AW-1:0]   BASE_VEC = {32'h900, 32'h800, 32'h0},
    parameter logic [NS*AW-1:0]   MASK_VEC = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00},
    parameter int                 RD_LAT   = 1,
    localparam int                SW       = $clog2(NS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    output logic          ready,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [NS-1:0] we_o,
    output logic [SW-1:0] rd_sel,
    output logic          rd_sel_vld,
    output logic          err,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr
);
    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    typedef enum logic {IDLE, RD_HOLD} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [NS-1:0] hit;
    logic [NS-1:0] we_nxt;
    logic [SW-1:0] sel_nxt;
    logic          any_hit;
    logic          accept;

    for (genvar g = 0; g < NS; g++) begin : g_region
        bus_addr_decoder_match #(.AW(AW)) u_match (
            .base (BASE_VEC[g*AW +: AW]),
            .mask (MASK_VEC[g*AW +: AW]),
            .addr (addr),
            .hit  (hit[g])
        );
    end

    // Scan from the top down so the lowest-index hit is the one left standing.
    always_comb begin
        sel_nxt = '0;
        we_nxt  = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_nxt   = SW'(i + 1);
                we_nxt    = '0;
                we_nxt[i] = 1'b1;
            end
        end
    end

    assign any_hit = |hit;
    assign ready   = (state == IDLE);
    assign accept  = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_o       <= '0;
            rd_sel     <= '0;
            rd_sel_vld <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
        end else begin
            we_o <= '0;
            case (state)
                IDLE: begin
                    if (accept && any_hit) begin
                        if (we) begin
                            we_o <= we_nxt;
                        end else begin
                            rd_sel     <= sel_nxt;
                            rd_sel_vld <= 1'b1;
                            cnt        <= CNT_LOAD;
                            state      <= RD_HOLD;
                        end
                    end
                end
                RD_HOLD: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        rd_sel     <= '0;
                        rd_sel_vld <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh unmapped access beats a simultaneous clear.
            if (accept && !any_hit) begin
                err <= 1'b1;
                if (!err || err_clr) err_addr <= addr;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench: instance a uses default regions with RD_LAT=3, instance b uses
// overlapping regions 0/1 with RD_LAT=4.

module tb_bus_addr_decoder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    logic        a_rst_n, a_valid, a_we, a_err_clr;
    logic [31:0] a_addr;
    logic        a_ready, a_rd_sel_vld, a_err;
    logic [2:0]  a_we_o;
    logic [1:0]  a_rd_sel;
    logic [31:0] a_err_addr;

    logic        b_rst_n, b_valid, b_we, b_err_clr;
    logic [31:0] b_addr;
    logic        b_ready, b_rd_sel_vld, b_err;
    logic [2:0]  b_we_o;
    logic [1:0]  b_rd_sel;
    logic [31:0] b_err_addr;

    bus_addr_decoder #(.RD_LAT(3)) u_a (
        .clk(clk), .rst_n(a_rst_n), .valid(a_valid), .ready(a_ready), .addr(a_addr),
        .we(a_we), .we_o(a_we_o), .rd_sel(a_rd_sel), .rd_sel_vld(a_rd_sel_vld),
        .err(a_err), .err_addr(a_err_addr), .err_clr(a_err_clr)
    );

    bus_addr_decoder #(
        .RD_LAT(4),
        .BASE_VEC({32'h900, 32'h0, 32'h0}),
        .MASK_VEC({32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF00})
    ) u_b (
        .clk(clk), .rst_n(b_rst_n), .valid(b_valid), .ready(b_ready), .addr(b_addr),
        .we(b_we), .we_o(b_we_o), .rd_sel(b_rd_sel), .rd_sel_vld(b_rd_sel_vld),
        .err(b_err), .err_addr(b_err_addr), .err_clr(b_err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 0; b_rst_n = 0;
        a_valid = 0; a_we = 0; a_addr = 0; a_err_clr = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_err_clr = 0;
        #2;
        nchk++; if (a_we_o !== 3'b000) begin nerr++; $display("FAIL reset_we_o got %b exp 000", a_we_o); end
        nchk++; if (a_rd_sel !== 2'd0 || a_rd_sel_vld !== 1'b0) begin nerr++; $display("FAIL reset_rd got %0d/%b exp 0/0", a_rd_sel, a_rd_sel_vld); end
        nchk++; if (a_err !== 1'b0 || a_err_addr !== 32'h0) begin nerr++; $display("FAIL reset_err got %b/%h exp 0/0", a_err, a_err_addr); end
        tick(); tick();
        a_rst_n = 1; b_rst_n = 1;
        tick();
        nchk++; if (a_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", a_ready); end
    endtask

    task automatic test_write();
        a_valid = 1; a_we = 1; a_addr = 32'h40;
        tick();
        a_valid = 0;
        nchk++; if (a_we_o !== 3'b001) begin nerr++; $display("FAIL write_strobe got %b exp 001", a_we_o); end
        nchk++; if (a_rd_sel !== 2'd0 || a_err !== 1'b0 || a_ready !== 1'b1) begin nerr++; $display("FAIL write_side got sel=%0d err=%b rdy=%b exp 0/0/1", a_rd_sel, a_err, a_ready); end
        tick();
        nchk++; if (a_we_o !== 3'b000) begin nerr++; $display("FAIL write_pulse_end got %b exp 000", a_we_o); end
    endtask

    task automatic test_read_hold();
        a_valid = 1; a_we = 0; a_addr = 32'h804;
        tick();
        // A write is presented during the hold and must wait for ready.
        a_we = 1; a_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (a_rd_sel !== 2'd2 || a_rd_sel_vld !== 1'b1 || a_ready !== 1'b0 || a_we_o !== 3'b000) begin
                nerr++;
                $display("FAIL read_hold[%0d] got sel=%0d vld=%b rdy=%b we=%b exp 2/1/0/000", k, a_rd_sel, a_rd_sel_vld, a_ready, a_we_o);
            end
            tick();
        end
        nchk++; if (a_rd_sel !== 2'd0 || a_rd_sel_vld !== 1'b0 || a_ready !== 1'b1 || a_we_o !== 3'b000) begin nerr++; $display("FAIL read_end got sel=%0d vld=%b rdy=%b we=%b exp 0/0/1/000", a_rd_sel, a_rd_sel_vld, a_ready, a_we_o); end
        tick();
        a_valid = 0;
        nchk++; if (a_we_o !== 3'b001) begin nerr++; $display("FAIL read_held_write got %b exp 001", a_we_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [3] = '{32'h40, 32'h800, 32'h904};
        logic [2:0]  exps [3] = '{3'b001, 3'b010, 3'b100};
        a_valid = 1; a_we = 1;
        for (int k = 0; k < 3; k++) begin
            a_addr = adrs[k];
            tick();
            nchk++; if (a_we_o !== exps[k]) begin nerr++; $display("FAIL b2b[%0d] got %b exp %b", k, a_we_o, exps[k]); end
        end
        a_valid = 0;
        tick();
        nchk++; if (a_we_o !== 3'b000) begin nerr++; $display("FAIL b2b_end got %b exp 000", a_we_o); end
    endtask

    task automatic test_err();
        a_valid = 1; a_we = 1; a_addr = 32'hA00;
        tick();
        nchk++; if (a_we_o !== 3'b000 || a_err !== 1'b1 || a_err_addr !== 32'hA00) begin nerr++; $display("FAIL err_first got we=%b err=%b addr=%h exp 000/1/a00", a_we_o, a_err, a_err_addr); end
        a_addr = 32'hB00;
        tick();
        a_valid = 0;
        nchk++; if (a_we_o !== 3'b000 || a_err !== 1'b1 || a_err_addr !== 32'hA00) begin nerr++; $display("FAIL err_sticky got we=%b err=%b addr=%h exp 000/1/a00", a_we_o, a_err, a_err_addr); end
    endtask

    task automatic test_err_clr();
        a_valid = 1; a_we = 0; a_addr = 32'hC00; a_err_clr = 1;
        tick();
        a_valid = 0;
        nchk++; if (a_err !== 1'b1 || a_err_addr !== 32'hC00) begin nerr++; $display("FAIL err_clr_race got err=%b addr=%h exp 1/c00", a_err, a_err_addr); end
        nchk++; if (a_rd_sel !== 2'd0 || a_rd_sel_vld !== 1'b0 || a_ready !== 1'b1) begin nerr++; $display("FAIL unmapped_read got sel=%0d vld=%b rdy=%b exp 0/0/1", a_rd_sel, a_rd_sel_vld, a_ready); end
        tick();
        a_err_clr = 0;
        nchk++; if (a_err !== 1'b0 || a_err_addr !== 32'h0) begin nerr++; $display("FAIL err_clr got err=%b addr=%h exp 0/0", a_err, a_err_addr); end
    endtask

    task automatic test_overlap();
        b_valid = 1; b_we = 1; b_addr = 32'h10;
        tick();
        b_valid = 0;
        nchk++; if (b_we_o !== 3'b001) begin nerr++; $display("FAIL overlap got %b exp 001", b_we_o); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        b_valid = 1; b_we = 0; b_addr = 32'h900;
        tick();
        b_valid = 0;
        tick();
        nchk++; if (b_rd_sel !== 2'd3 || b_rd_sel_vld !== 1'b1 || b_ready !== 1'b0) begin nerr++; $display("FAIL midrd_pre got sel=%0d vld=%b rdy=%b exp 3/1/0", b_rd_sel, b_rd_sel_vld, b_ready); end
        b_rst_n = 0;
        #1;
        nchk++; if (b_rd_sel !== 2'd0 || b_rd_sel_vld !== 1'b0 || b_we_o !== 3'b000 || b_err !== 1'b0) begin nerr++; $display("FAIL midrd_async got sel=%0d vld=%b we=%b err=%b exp 0/0/000/0", b_rd_sel, b_rd_sel_vld, b_we_o, b_err); end
        tick();
        b_rst_n = 1;
        tick();
        nchk++; if (b_rd_sel_vld !== 1'b0 || b_ready !== 1'b1) begin nerr++; $display("FAIL midrd_residual got vld=%b rdy=%b exp 0/1", b_rd_sel_vld, b_ready); end
        b_valid = 1; b_addr = 32'h900;
        tick();
        b_valid = 0;
        for (int k = 0; k < 4; k++) begin
            nchk++; if (b_rd_sel !== 2'd3 || b_rd_sel_vld !== 1'b1) begin nerr++; $display("FAIL post_rst_rd[%0d] got sel=%0d vld=%b exp 3/1", k, b_rd_sel, b_rd_sel_vld); end
            tick();
        end
        nchk++; if (b_rd_sel !== 2'd0 || b_rd_sel_vld !== 1'b0 || b_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_end got sel=%0d vld=%b rdy=%b exp 0/0/1", b_rd_sel, b_rd_sel_vld, b_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_back_to_back();
        test_err();
        test_err_clr();
        test_overlap();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bus_addr_decoder.md
BUS_ADDR_DECODER -- requirements
Module: bus_addr_decoder

Interface
REQ-001 SHALL have parameter NS, default 3: number of decoded regions, 1..16.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter BASE_VEC, default {32'h900,32'h800,32'h0}: NS packed AW-bit region bases; region i occupies bits [i*AW +: AW].
REQ-004 SHALL have parameter MASK_VEC, default {32'hFFFF_FFF0,32'hFFFF_FFF0,32'hFFFF_FF00}: NS packed AW-bit compare masks.
REQ-005 SHALL have parameter RD_LAT, default 1: read-select hold cycles, 1..15.
REQ-006 SHALL define SW = clog2(NS+1) as a localparam.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 valid  in  1  transfer request.
REQ-010 ready  out  1  block accepts when valid&&ready.
REQ-011 addr  in  AW  transfer address.
REQ-012 we  in  1  1=write, 0=read.
REQ-013 we_o  out  NS  one-hot write strobe per region.
REQ-014 rd_sel  out  SW  read mux select: region index+1; 0 means none.
REQ-015 rd_sel_vld  out  1  rd_sel is valid for the read in progress.
REQ-016 err  out  1  sticky flag: an unmapped access occurred.
REQ-017 err_addr  out  AW  address of the first unmapped access.
REQ-018 err_clr  in  1  clears err and err_addr.

Function
REQ-019 Region i SHALL hit when (addr & MASK_i) == (BASE_i & MASK_i); on overlapping hits the lowest index SHALL win.
REQ-020 The FSM SHALL have states IDLE and RD_HOLD; ready SHALL be 1 in IDLE and 0 in RD_HOLD.
REQ-021 An accepted write that hits region i SHALL assert we_o[i] for exactly the next cycle (1-cycle latency, registered); all other we_o bits SHALL stay 0; the FSM SHALL stay in IDLE.
REQ-022 An accepted read that hits region i SHALL, from the next cycle, drive rd_sel=i+1 and rd_sel_vld=1 for RD_LAT cycles; the FSM SHALL go to RD_HOLD, with a down-counter loaded with RD_LAT-1.
REQ-023 In RD_HOLD the counter SHALL decrement each cycle; when it is 0 the FSM SHALL return to IDLE and, on that same edge, rd_sel SHALL become 0 and rd_sel_vld SHALL become 0.
REQ-024 An accepted access that hits no region SHALL produce no we_o pulse, leave rd_sel=0 and rd_sel_vld=0, and stay in IDLE.
REQ-025 An accepted unmapped access SHALL set err on the next edge.
REQ-026 err_addr SHALL be captured only when err is 0; later unmapped accesses SHALL NOT overwrite it.
REQ-027 err_clr SHALL clear err and err_addr to 0 on the next edge.
REQ-028 If err_clr and an unmapped accept occur in the same cycle, the new error SHALL win: err=1 and err_addr=the new address.
REQ-029 valid while ready=0 SHALL be ignored; the requester SHALL hold addr, we and valid until accepted.
REQ-030 Back-to-back writes SHALL be accepted every cycle, producing consecutive single-cycle strobes.
REQ-031 The outputs we_o, rd_sel, rd_sel_vld, err and err_addr SHALL all be registered.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, counter=0, we_o=0, rd_sel=0, rd_sel_vld=0, err=0, err_addr=0; ready=1 once rst_n=1.
REQ-033 Reset asserted mid-RD_HOLD SHALL abort the read immediately with no residual strobe.

Verification
REQ-034 Write to 0x0000_0040, defaults -> we_o=3'b001 for 1 cycle; rd_sel stays 0; err=0.
REQ-035 Read from 0x0000_0804 with RD_LAT=3 -> rd_sel=2 and rd_sel_vld=1 for 3 cycles; ready=0 for those 3 cycles; a valid presented during the hold is not accepted until ready returns.
REQ-036 Write to 0x0000_0A00, then write to 0x0000_0B00 -> no strobes; err=1; err_addr=0x0000_0A00.
REQ-037 err_clr pulsed in the same cycle as a read to 0x0000_0C00 -> err=1; err_addr=0x0000_0C00.
REQ-038 Overlapping parameters (region 1 base 0x0, mask 0xFFFF_FF00) with a write to 0x10 -> only we_o[0] pulses.
REQ-039 rst_n dropped in the 2nd cycle of an RD_LAT=4 read -> all outputs 0 immediately; the first access after release behaves normally.
